// File: rtl/tv80_bus_bridge_pkg.sv
// tv80_bus_bridge_pkg: shared definitions for the tv80 bus bridge.
//   state_e  - one-hot FSM state encoding (5 bits)
//   cyc_e    - Z80 bus-cycle classification codes
//   OpenBusDefault - data value returned when nothing drives the bus
package tv80_bus_bridge_pkg;

   typedef enum logic [4:0] {
      StIdle = 5'b00001,
      StReq  = 5'b00010,
      StWack = 5'b00100,
      StDone = 5'b01000,
      StHold = 5'b10000
   } state_e;

   typedef enum logic [2:0] {
      CycNone = 3'd0,
      CycMrd  = 3'd1,
      CycMwr  = 3'd2,
      CycIord = 3'd3,
      CycIowr = 3'd4,
      CycInta = 3'd5
   } cyc_e;

   localparam logic [7:0] OpenBusDefault = 8'hFF;

   function automatic logic cyc_is_io(cyc_e c);
      return (c == CycIord) || (c == CycIowr);
   endfunction

   function automatic logic cyc_is_write(cyc_e c);
      return (c == CycMwr) || (c == CycIowr);
   endfunction

endpackage

// File: rtl/tv80_bus_bridge_cyc_decode.sv
// tv80_bus_bridge_cyc_decode: combinational Z80 bus-cycle classifier.
// Ports:
//   m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n - registered CPU strobes
//   cyc_type - cyc_e code of the current cycle (CycNone when idle)
//   active   - any classified cycle in progress
module tv80_bus_bridge_cyc_decode
   import tv80_bus_bridge_pkg::*;
(
   input  logic       m1_n,
   input  logic       mreq_n,
   input  logic       iorq_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic       rfsh_n,
   output logic [2:0] cyc_type,
   output logic       active
);

   cyc_e cyc;

   always_comb begin
      cyc = CycNone;
      // INTA first: iorq with m1 low is never a plain IO access.
      if (!iorq_n && !m1_n)                cyc = CycInta;
      else if (!iorq_n && !rd_n)           cyc = CycIord;
      else if (!iorq_n && !wr_n)           cyc = CycIowr;
      else if (!mreq_n && !wr_n)           cyc = CycMwr;
      // Refresh keeps mreq_n low with rfsh_n low; it must not look like a read.
      else if (!mreq_n && !rd_n && rfsh_n) cyc = CycMrd;
   end

   assign cyc_type = cyc;
   assign active   = (cyc != CycNone);

endmodule

// File: rtl/tv80_bus_bridge.sv
// tv80_bus_bridge: turns each Z80 bus cycle into one req/ack fabric transaction,
// stretching the CPU with wait_n until the fabric answers.
// Ports:
//   clk, reset_n                    - clock, synchronous active-low reset
//   m1_n..rfsh_n, A, dout           - registered CPU strobes, address, write data
//   wait_n, di                      - CPU wait and read data / IM2 vector
//   int_vec                         - vector returned on INTA
//   bus_req, bus_io, bus_we,
//   bus_addr, bus_wdata             - fabric request (req is a 1-cycle pulse)
//   bus_ack, bus_rdata              - fabric completion and read data
//   err, err_clr                    - sticky timeout flag and its clear
module tv80_bus_bridge
   import tv80_bus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [7:0]  OPEN_BUS = OpenBusDefault
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [15:0] A,
   input  logic [7:0]  dout,
   output logic        wait_n,
   output logic [7:0]  di,
   input  logic [7:0]  int_vec,
   output logic        bus_req,
   output logic        bus_io,
   output logic        bus_we,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic        bus_ack,
   input  logic [7:0]  bus_rdata,
   output logic        err,
   input  logic        err_clr
);

   logic [2:0] cyc_type;
   logic       active;
   cyc_e       cyc;
   state_e     state_q, state_d;
   logic [7:0] cnt_q;
   logic       ack_done;
   logic       timeout;

   tv80_bus_bridge_cyc_decode u_decode (
      .m1_n     (m1_n),
      .mreq_n   (mreq_n),
      .iorq_n   (iorq_n),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .rfsh_n   (rfsh_n),
      .cyc_type (cyc_type),
      .active   (active)
   );

   assign cyc = cyc_e'(cyc_type);

   always_comb begin
      state_d  = state_q;
      bus_req  = 1'b0;
      ack_done = 1'b0;
      timeout  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cyc == CycInta) state_d = StDone;
            else if (active)    state_d = StReq;
         end
         StReq: begin
            bus_req = 1'b1;
            if (bus_ack) begin
               ack_done = 1'b1;
               state_d  = StDone;
            end else begin
               state_d  = StWack;
            end
         end
         StWack: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (bus_ack) begin
               ack_done = 1'b1;
               state_d  = StDone;
            end else if (TIMEOUT != 0 && (32'(cnt_q) + 32'd1) >= TIMEOUT) begin
               timeout = 1'b1;
               state_d = StDone;
            end
         end
         StDone: state_d = StHold;
         StHold: if (!active) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Combinational so the CPU sees the stretch in its first T2 cycle.
   assign wait_n = ~(active && (state_q == StIdle || state_q == StReq || state_q == StWack));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         di        <= OPEN_BUS;
         err       <= 1'b0;
         bus_addr  <= 16'd0;
         bus_wdata <= 8'd0;
         bus_io    <= 1'b0;
         bus_we    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && active && cyc != CycInta) begin
            bus_addr  <= A;
            bus_wdata <= dout;
            bus_io    <= cyc_is_io(cyc);
            bus_we    <= cyc_is_write(cyc);
            cnt_q     <= 8'd0;
         end
         if (state_q == StIdle && cyc == CycInta) di <= int_vec;
         if (state_q == StWack && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
         if (ack_done && !bus_we) di <= bus_rdata;
         if (timeout && !bus_we)  di <= OPEN_BUS;
         if (timeout)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
module tb_tv80_bus_bridge;

   localparam int TO = 4;
   localparam int K_MRD = 0, K_MWR = 1, K_IORD = 2, K_IOWR = 3, K_INTA = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic [15:0] A;
   logic [7:0]  dout, di, int_vec, bus_wdata, bus_rdata;
   logic        wait_n, bus_req, bus_io, bus_we, bus_ack, err, err_clr;
   logic [15:0] bus_addr;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_di  = 8'hFF;
   logic       exp_err = 1'b0;

   tv80_bus_bridge #(.TIMEOUT(TO), .OPEN_BUS(8'hFF)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .m1_n      (m1_n),
      .mreq_n    (mreq_n),
      .iorq_n    (iorq_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .rfsh_n    (rfsh_n),
      .A         (A),
      .dout      (dout),
      .wait_n    (wait_n),
      .di        (di),
      .int_vec   (int_vec),
      .bus_req   (bus_req),
      .bus_io    (bus_io),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .err       (err),
      .err_clr   (err_clr)
   );

   task automatic strobes_idle();
      m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
   endtask

   task automatic strobes_set(input int kind);
      strobes_idle();
      case (kind)
         K_MRD:  begin mreq_n = 0; rd_n = 0; m1_n = 1'($urandom % 2); end
         K_MWR:  begin mreq_n = 0; wr_n = 0; end
         K_IORD: begin iorq_n = 0; rd_n = 0; end
         K_IOWR: begin iorq_n = 0; wr_n = 0; end
         default: begin iorq_n = 0; m1_n = 0; end
      endcase
   endtask

   // One CPU bus cycle. dly: ack offset in cycles after the bus_req cycle (<0 = never).
   // clr_off: pulse err_clr at this offset after bus_req (<0 = never).
   task automatic run_txn(input int kind, input logic [15:0] addr, input logic [7:0] wdata,
                          input int dly, input logic [7:0] rdata, input logic [7:0] vec,
                          input int clr_off, input string name);
      int low, reqs, req_idx, exp_low;
      logic got_high, has_req, is_rd, is_wr, is_io, to;
      logic [7:0] want_di;
      has_req = (kind != K_INTA);
      is_rd   = (kind == K_MRD) || (kind == K_IORD);
      is_wr   = (kind == K_MWR) || (kind == K_IOWR);
      is_io   = (kind == K_IORD) || (kind == K_IOWR);
      to      = has_req && (dly < 0 || dly > TO);
      exp_low = !has_req ? 1 : (to ? 2 + TO : 2 + dly);
      want_di = (kind == K_INTA) ? vec : (is_rd ? (to ? 8'hFF : rdata) : exp_di);

      @(negedge clk);
      A = addr; dout = wdata; int_vec = vec; bus_rdata = rdata; bus_ack = 0; err_clr = 0;
      strobes_set(kind);
      low = 0; reqs = 0; req_idx = -1; got_high = 0;
      for (int idx = 0; idx < 40 && !got_high; idx++) begin
         #1;
         if (bus_req) begin
            reqs++;
            req_idx = idx;
            total++;
            if (bus_addr !== addr || bus_io !== is_io || bus_we !== is_wr ||
                (is_wr && bus_wdata !== wdata)) begin
               bad++;
               $display("FAIL %s fields: addr=%h io=%b we=%b wdata=%h want %h %b %b %h",
                        name, bus_addr, bus_io, bus_we, bus_wdata, addr, is_io, is_wr, wdata);
            end
         end
         bus_ack = (req_idx >= 0 && dly >= 0 && idx - req_idx == dly);
         err_clr = (req_idx >= 0 && clr_off >= 0 && idx - req_idx == clr_off);
         if (wait_n) got_high = 1;
         else begin
            low++;
            @(negedge clk);
         end
      end
      total++;
      if (!got_high) begin
         bad++;
         $display("FAIL %s wait_n never rose: got low=%0d want %0d", name, low, exp_low);
      end
      total++;
      if (low != exp_low) begin
         bad++;
         $display("FAIL %s stretch: got %0d cycles want %0d", name, low, exp_low);
      end
      total++;
      if (di !== want_di) begin
         bad++;
         $display("FAIL %s di: got %h want %h", name, di, want_di);
      end
      exp_di = want_di;
      if (to) exp_err = 1'b1;

      @(negedge clk);
      bus_ack = 0; err_clr = 0;
      strobes_idle();
      // Spurious acks in HOLD/IDLE must be ignored.
      for (int i = 0; i < 3; i++) begin
         #1;
         if (bus_req) reqs++;
         bus_ack = 1'($urandom % 2);
         @(negedge clk);
      end
      bus_ack = 0;
      total++;
      if (reqs != (has_req ? 1 : 0)) begin
         bad++;
         $display("FAIL %s req count: got %0d want %0d", name, reqs, has_req ? 1 : 0);
      end
      total++;
      if (err !== exp_err || di !== exp_di) begin
         bad++;
         $display("FAIL %s after: err=%b di=%h want err=%b di=%h", name, err, di, exp_err, exp_di);
      end
   endtask

   task automatic test_reset();
      reset_n = 0; strobes_idle(); A = 0; dout = 0; int_vec = 0;
      bus_ack = 0; bus_rdata = 0; err_clr = 0;
      repeat (3) @(negedge clk);
      reset_n = 1;
      #1;
      total++;
      if (wait_n !== 1 || bus_req !== 0 || di !== 8'hFF || err !== 0 || bus_addr !== 0 ||
          bus_wdata !== 0 || bus_io !== 0 || bus_we !== 0) begin
         bad++;
         $display("FAIL reset: wait_n=%b req=%b di=%h err=%b addr=%h wdata=%h io=%b we=%b",
                  wait_n, bus_req, di, err, bus_addr, bus_wdata, bus_io, bus_we);
      end
      exp_di = 8'hFF; exp_err = 0;
   endtask

   task automatic test_directed();
      run_txn(K_MRD, 16'h4000, 8'h00, 2, 8'h5A, 8'h00, -1, "mrd");
      run_txn(K_IOWR, 16'h00FE, 8'h07, 0, 8'h00, 8'h00, -1, "iowr");
      run_txn(K_INTA, 16'h0000, 8'h00, -1, 8'h00, 8'hFF, -1, "inta");
   endtask

   task automatic test_refresh();
      int reqs = 0, lows = 0;
      run_txn(K_MRD, 16'h0100, 8'h00, 1, 8'hC3, 8'h00, -1, "m1_fetch");
      @(negedge clk);
      mreq_n = 0; rfsh_n = 0; A = 16'h007F;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (bus_req) reqs++;
         if (!wait_n) lows++;
         @(negedge clk);
      end
      strobes_idle();
      total++;
      if (reqs != 0 || lows != 0) begin
         bad++;
         $display("FAIL refresh: got reqs=%0d wait_low=%0d want 0 0", reqs, lows);
      end
   endtask

   task automatic test_timeout();
      run_txn(K_IORD, 16'h0012, 8'h00, -1, 8'h00, 8'h00, -1, "iord_timeout");
      @(negedge clk); err_clr = 1;
      @(negedge clk); err_clr = 0;
      exp_err = 0;
      total++;
      if (err !== 0) begin
         bad++;
         $display("FAIL err_clr: got err=%b want 0", err);
      end
      // err_clr lands in the same cycle as the timeout: set wins.
      run_txn(K_IORD, 16'h0013, 8'h00, -1, 8'h00, 8'h00, TO, "clr_vs_timeout");
      @(negedge clk); err_clr = 1;
      @(negedge clk); err_clr = 0;
      exp_err = 0;
      // Ack in the same cycle as the timeout: ack wins.
      run_txn(K_MRD, 16'h2222, 8'h00, TO, 8'h3C, 8'h00, -1, "ack_vs_timeout");
   endtask

   task automatic test_reset_mid();
      int reqs = 0;
      @(negedge clk);
      A = 16'h1234; strobes_set(K_MRD); bus_ack = 0;
      repeat (3) @(negedge clk);
      reset_n = 0; strobes_idle();
      #1;
      total++;
      if (wait_n !== 1) begin
         bad++;
         $display("FAIL reset_mid wait_n: got %b want 1", wait_n);
      end
      @(negedge clk); reset_n = 1;
      exp_di = 8'hFF; exp_err = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         if (bus_req) reqs++;
         bus_ack = (i == 2); bus_rdata = 8'h99;
         @(negedge clk);
      end
      bus_ack = 0;
      total++;
      if (reqs != 0 || di !== 8'hFF || err !== 0 || bus_addr !== 16'h0) begin
         bad++;
         $display("FAIL reset_mid: reqs=%0d di=%h err=%b addr=%h want 0 ff 0 0000",
                  reqs, di, err, bus_addr);
      end
      run_txn(K_MRD, 16'h4001, 8'h00, 1, 8'hA5, 8'h00, -1, "mrd_after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int kind, dly;
         kind = int'($urandom_range(0, 4));
         dly  = int'($urandom_range(0, 7));
         if (dly == 7) dly = -1;
         run_txn(kind, 16'($urandom), 8'($urandom), dly, 8'($urandom), 8'($urandom), -1,
                 "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_refresh();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
